// File: rtl/id_ex_reg_pkg.sv
// rtl/id_ex_reg_pkg.sv - shared MIPS pipeline widths, ID/EX stage record and bubble encoding
package id_ex_reg_pkg;

   localparam int ALU_CTRL_W   = 4;
   localparam int REG_W        = 5;
   localparam int DATA_W       = 32;
   localparam int BUBBLE_CNT_W = 16;

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_to_reg;
      logic                  mem_write;
      logic                  branch;
      logic                  alu_src;
      logic                  reg_dst;
      logic [ALU_CTRL_W-1:0] alu_control;
   } ctrl_t;

   typedef struct packed {
      logic              valid;
      ctrl_t             ctrl;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] sign_imm;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
   } stage_t;

   // A bubble is an all-zero stage: no writes, no memory access, not valid.
   localparam stage_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/id_ex_reg_if.sv
// rtl/id_ex_reg_if.sv - decode-to-execute bus; BubbleCnt present only with IDEX_BUBBLE_CNT_EN
interface id_ex_reg_if;
   import id_ex_reg_pkg::*;

   logic                  RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD;
   logic [ALU_CTRL_W-1:0] ALUControlD;
   logic [DATA_W-1:0]     RD1D, RD2D, SignImmD;
   logic [REG_W-1:0]      RsD, RtD, RdD;
   logic                  FlushE;

   logic                  RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE;
   logic [ALU_CTRL_W-1:0] ALUControlE;
   logic [DATA_W-1:0]     RD1E, RD2E, SignImmE;
   logic [REG_W-1:0]      RsE, RtE, RdE;
   logic                  ValidE;
   logic                  StallF, StallD;
`ifdef IDEX_BUBBLE_CNT_EN
   logic [BUBBLE_CNT_W-1:0] BubbleCnt;
`endif

   modport slave (
      input  RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD, ALUControlD,
      input  RD1D, RD2D, SignImmD, RsD, RtD, RdD, FlushE,
      output RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, ALUControlE,
      output RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE,
`ifdef IDEX_BUBBLE_CNT_EN
      output BubbleCnt,
`endif
      output StallF, StallD
   );

   modport master (
      output RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, RegDstD, ALUControlD,
      output RD1D, RD2D, SignImmD, RsD, RtD, RdD, FlushE,
      input  RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE, ALUControlE,
      input  RD1E, RD2E, SignImmE, RsE, RtE, RdE, ValidE,
`ifdef IDEX_BUBBLE_CNT_EN
      input  BubbleCnt,
`endif
      input  StallF, StallD
   );

endinterface

// File: rtl/id_ex_reg_hazard_lw.sv
// rtl/id_ex_reg_hazard_lw.sv - load-use hazard detect between a load in EX and the instruction in ID
module hazard_lw
   import id_ex_reg_pkg::*;
(
   input  logic             mem_to_reg_e,
   input  logic             reg_write_e,
   input  logic [REG_W-1:0] rt_e,
   input  logic [REG_W-1:0] rs_d,
   input  logic [REG_W-1:0] rt_d,
   output logic             lwstall
);

   // $zero is never really written, so a load targeting it cannot create a dependency.
   assign lwstall = mem_to_reg_e & reg_write_e & (rt_e != '0) &
                    ((rt_e == rs_d) | (rt_e == rt_d));

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with load-use stall and flush bubbles
// Optional bubble counter enabled by IDEX_BUBBLE_CNT_EN.
module id_ex_reg
   import id_ex_reg_pkg::*;
(
   input logic         clk,
   input logic         rst_n,
   id_ex_reg_if.slave  bus
);

   logic   lwstall;
   logic   bubble;
   stage_t d_stage;
   stage_t e_q;

   hazard_lw u_hazard_lw (
      .mem_to_reg_e (e_q.ctrl.mem_to_reg),
      .reg_write_e  (e_q.ctrl.reg_write),
      .rt_e         (e_q.rt),
      .rs_d         (bus.RsD),
      .rt_d         (bus.RtD),
      .lwstall      (lwstall)
   );

   assign bus.StallF = lwstall;
   assign bus.StallD = lwstall;

   // Stall and flush collapse into one bubble; the bubble clears MemtoRegE, so a stall never repeats.
   assign bubble = lwstall | bus.FlushE;

   always_comb begin
      d_stage                  = STAGE_BUBBLE;
      d_stage.valid            = 1'b1;
      d_stage.ctrl.reg_write   = bus.RegWriteD;
      d_stage.ctrl.mem_to_reg  = bus.MemtoRegD;
      d_stage.ctrl.mem_write   = bus.MemWriteD;
      d_stage.ctrl.branch      = bus.BranchD;
      d_stage.ctrl.alu_src     = bus.ALUSrcD;
      d_stage.ctrl.reg_dst     = bus.RegDstD;
      d_stage.ctrl.alu_control = bus.ALUControlD;
      d_stage.rd1              = bus.RD1D;
      d_stage.rd2              = bus.RD2D;
      d_stage.sign_imm         = bus.SignImmD;
      d_stage.rs               = bus.RsD;
      d_stage.rt               = bus.RtD;
      d_stage.rd               = bus.RdD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         e_q <= STAGE_BUBBLE;
      else if (bubble)
         e_q <= STAGE_BUBBLE;
      else
         e_q <= d_stage;
   end

   assign bus.RegWriteE   = e_q.ctrl.reg_write;
   assign bus.MemtoRegE   = e_q.ctrl.mem_to_reg;
   assign bus.MemWriteE   = e_q.ctrl.mem_write;
   assign bus.BranchE     = e_q.ctrl.branch;
   assign bus.ALUSrcE     = e_q.ctrl.alu_src;
   assign bus.RegDstE     = e_q.ctrl.reg_dst;
   assign bus.ALUControlE = e_q.ctrl.alu_control;
   assign bus.RD1E        = e_q.rd1;
   assign bus.RD2E        = e_q.rd2;
   assign bus.SignImmE    = e_q.sign_imm;
   assign bus.RsE         = e_q.rs;
   assign bus.RtE         = e_q.rt;
   assign bus.RdE         = e_q.rd;
   assign bus.ValidE      = e_q.valid;

`ifdef IDEX_BUBBLE_CNT_EN
   logic [BUBBLE_CNT_W-1:0] bubble_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bubble_cnt <= '0;
      else if (bubble && (bubble_cnt != '1))
         bubble_cnt <= bubble_cnt + 1'b1;
   end

   assign bus.BubbleCnt = bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed bench for id_ex_reg; bubble-count checks follow IDEX_BUBBLE_CNT_EN
module tb_id_ex_reg;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   exp_bub;

   id_ex_reg_if bus ();

   id_ex_reg dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag);
`ifdef IDEX_BUBBLE_CNT_EN
      chk(tag, {16'h0, bus.BubbleCnt}, exp_bub);
`endif
   endtask

   task automatic clear_d();
      bus.RegWriteD = 0; bus.MemtoRegD = 0; bus.MemWriteD = 0; bus.BranchD = 0;
      bus.ALUSrcD = 0; bus.RegDstD = 0; bus.ALUControlD = 0;
      bus.RD1D = 0; bus.RD2D = 0; bus.SignImmD = 0;
      bus.RsD = 0; bus.RtD = 0; bus.RdD = 0;
   endtask

   task automatic drive_lw(input logic [4:0] rt);
      clear_d();
      bus.RegWriteD = 1; bus.MemtoRegD = 1; bus.ALUSrcD = 1; bus.ALUControlD = 4'b0010;
      bus.RsD = 5'd9; bus.RtD = rt; bus.SignImmD = 32'h10; bus.RD1D = 32'h100;
   endtask

   initial begin
      n_cmp = 0; n_err = 0; exp_bub = 0;
      rst_n = 1'b0;
      bus.FlushE = 1'b0;
      bus.RegWriteD = 1; bus.MemtoRegD = 1; bus.MemWriteD = 1; bus.BranchD = 1;
      bus.ALUSrcD = 1; bus.RegDstD = 1; bus.ALUControlD = 4'hF;
      bus.RD1D = 32'hDEAD_BEEF; bus.RD2D = 32'h1234_5678; bus.SignImmD = 32'hFFFF_FFFF;
      bus.RsD = 5'd7; bus.RtD = 5'd7; bus.RdD = 5'd31;

      // reset holds everything at zero despite nonzero D inputs
      repeat (2) @(negedge clk);
      chk("rst_ctrl", {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.BranchE,
                       bus.ALUSrcE, bus.RegDstE, bus.ALUControlE}, 0);
      chk("rst_data", bus.RD1E | bus.RD2E | bus.SignImmE, 0);
      chk("rst_regs", {bus.RsE, bus.RtE, bus.RdE}, 0);
      chk("rst_valid", bus.ValidE, 0);
      chk("rst_stall", {bus.StallF, bus.StallD}, 0);
      chk_cnt("rst_cnt");

      // add: pass-through with one-cycle latency
      clear_d();
      bus.RegWriteD = 1; bus.RegDstD = 1; bus.ALUControlD = 4'b0010;
      bus.RD1D = 32'h5; bus.RD2D = 32'h7; bus.RsD = 5'd1; bus.RtD = 5'd2; bus.RdD = 5'd3;
      rst_n = 1'b1;
      #1;
      chk("latency_rd1", bus.RD1E, 0);
      chk("latency_valid", bus.ValidE, 0);
      @(negedge clk);
      chk("add_ctrl", {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.BranchE,
                       bus.ALUSrcE, bus.RegDstE, bus.ALUControlE}, 32'b100001_0010);
      chk("add_rd1", bus.RD1E, 32'h5);
      chk("add_rd2", bus.RD2E, 32'h7);
      chk("add_regs", {bus.RsE, bus.RtE, bus.RdE}, {5'd1, 5'd2, 5'd3});
      chk("add_valid", bus.ValidE, 1);
      chk("add_stall", bus.StallD, 0);

      // load-use on RsD
      drive_lw(5'd8);
      @(negedge clk);
      chk("lw_mem2reg", bus.MemtoRegE, 1);
      chk("lw_rt", bus.RtE, 8);
      chk("lw_imm", bus.SignImmE, 32'h10);
      clear_d();
      bus.RegWriteD = 1; bus.RegDstD = 1; bus.RsD = 5'd8; bus.RtD = 5'd4; bus.RdD = 5'd10;
      bus.RD1D = 32'hAA;
      #1;
      chk("lu_stall", {bus.StallF, bus.StallD}, 2'b11);
      @(negedge clk);
      exp_bub++;
      chk("lu_bubble_valid", bus.ValidE, 0);
      chk("lu_bubble_m2r", bus.MemtoRegE, 0);
      chk("lu_bubble_regs", {bus.RsE, bus.RtE, bus.RdE, bus.RegWriteE}, 0);
      chk("lu_stall_clear", {bus.StallF, bus.StallD}, 0);
      chk_cnt("lu_cnt");
      @(negedge clk);
      chk("lu_resume", {bus.ValidE, bus.RsE, bus.RdE}, {1'b1, 5'd8, 5'd10});
      chk("lu_resume_rd1", bus.RD1E, 32'hAA);

      // load-use on RtD
      drive_lw(5'd12);
      @(negedge clk);
      clear_d();
      bus.RsD = 5'd3; bus.RtD = 5'd12;
      #1;
      chk("lu_rt_stall", bus.StallF, 1);

      // load targeting $zero never stalls
      @(negedge clk);
      exp_bub++;
      drive_lw(5'd0);
      @(negedge clk);
      clear_d();
      bus.RegWriteD = 1; bus.RdD = 5'd6;
      #1;
      chk("r0_stall", {bus.StallF, bus.StallD}, 0);
      @(negedge clk);
      chk("r0_nobubble", {bus.ValidE, bus.RdE}, {1'b1, 5'd6});
      chk_cnt("r0_cnt");

      // flush and load-use together: single bubble
      drive_lw(5'd8);
      @(negedge clk);
      clear_d();
      bus.MemWriteD = 1; bus.RsD = 5'd8; bus.RtD = 5'd2; bus.RD2D = 32'h55;
      bus.FlushE = 1'b1;
      #1;
      chk("sim_stall", bus.StallD, 1);
      @(negedge clk);
      exp_bub++;
      chk("sim_memwrite", bus.MemWriteE, 0);
      chk("sim_valid", bus.ValidE, 0);
      chk_cnt("sim_cnt");

      // flush alone, then the held sw passes
      @(negedge clk);
      exp_bub++;
      chk("flush_valid", bus.ValidE, 0);
      chk_cnt("flush_cnt");
      bus.FlushE = 1'b0;
      @(negedge clk);
      chk("post_flush", {bus.ValidE, bus.MemWriteE, bus.RsE}, {1'b1, 1'b1, 5'd8});
      chk("post_flush_rd2", bus.RD2E, 32'h55);

      // asynchronous reset mid-stall cancels the stall immediately
      drive_lw(5'd8);
      @(negedge clk);
      clear_d();
      bus.RsD = 5'd8;
      #2;
      rst_n = 1'b0;
      #1;
      exp_bub = 0;
      chk("arst_valid", {bus.ValidE, bus.MemtoRegE, bus.RtE}, 0);
      chk("arst_stall", {bus.StallF, bus.StallD}, 0);
      chk_cnt("arst_cnt");
      @(negedge clk);
      rst_n = 1'b1;
      clear_d();

`ifdef IDEX_BUBBLE_CNT_EN
      // saturation, then async reset clears the counter without a clock edge
      bus.FlushE = 1'b1;
      repeat (65540) @(posedge clk);
      @(negedge clk);
      exp_bub = 32'hFFFF;
      chk_cnt("sat_cnt");
      bus.FlushE = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      exp_bub = 0;
      chk_cnt("sat_arst_cnt");
      chk("sat_arst_valid", bus.ValidE, 0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
